button_debouncer: RTL and testbench

//  - Synchronises and debounces N raw push-button inputs from board pins.
//  - Produces clean, glitch-free levels.
//  - Sits directly upstream of the per-button transition/edge detectors in the menu subsystem.
//  - Each clean level changes only after the synchronised input has held a new value for

---
 rtl/button_pkg.sv | 13 +
 rtl/debounce_channel.sv | 91 +++++++++
 rtl/button_debouncer.sv | 35 +++
 tb/tb_button_debouncer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and types for the push-button debouncer.
// The optional long-press detector is enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
package button_pkg;

  // Defaults sized for a 100 MHz system clock.
  localparam int N_BTN_DEF         = 5;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_DEF = 1_000_000;   // 10 ms
  localparam int HOLD_CYCLES_DEF   = 100_000_000; // 1 s

  typedef logic [N_BTN_DEF-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: metastability synchroniser, debounce counter and,
// when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined, a saturating long-press timer.
module debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_held
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic [CW-1:0]          cnt_reg;
  logic [CW-1:0]          cnt_next;
  logic                   clean_reg;
  logic                   clean_next;

  assign sync_out  = sync_reg[SYNC_STAGES-1];
  assign btn_clean = clean_reg;

  // Debounce decision: any sample agreeing with the clean level restarts the
  // count; the change is accepted on the STABLE_CYCLES-th differing sample.
  always_comb begin
    clean_next = clean_reg;
    cnt_next   = cnt_reg;
    if (sync_out == clean_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == STABLE_LAST) begin
      clean_next = sync_out;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Synchroniser chain, debounce counter and clean level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      clean_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
      cnt_reg   <= cnt_next;
      clean_reg <= clean_next;
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt_reg;
  logic          held_reg;

  assign btn_held = held_reg;

  // Long-press timer: counts edges with the clean level high, and clears on
  // the same edge the clean level drops (hence the look at clean_next).
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_reg <= '0;
      held_reg     <= 1'b0;
    end else if (!clean_next) begin
      hold_cnt_reg <= '0;
      held_reg     <= 1'b0;
    end else if (clean_reg && (hold_cnt_reg != HOLD_MAX)) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
      if (hold_cnt_reg == HOLD_LAST) begin
        held_reg <= 1'b1;
      end
    end
  end
`else
  // No long-press hardware; the hold length only matters when it is built.
  logic unused_hold_cfg;
  assign unused_hold_cfg = (HOLD_CYCLES > 0);
  assign btn_held        = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// N-channel push-button synchroniser/debouncer feeding the menu edge detectors.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to build the per-button long-press flags.
module button_debouncer
  import button_pkg::*;
#(
  parameter int N_BTN         = N_BTN_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_held
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw[gi]),
        .btn_clean(btn_clean[gi]),
        .btn_held (btn_held[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with short timing constants. The reference model
// keeps a history of raw samples and accepts a new level when a full window of
// samples (delayed by the synchroniser) agrees and differs from the clean level.
module tb_button_debouncer;
  import button_pkg::*;

  localparam int N  = 5;
  localparam int SS = 2;
  localparam int ST = 4;
  localparam int HC = 8;
  localparam int HD = SS - 1 + ST;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_clean;
  logic [N-1:0] btn_held;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;

  logic [N-1:0] hist [HD];
  btn_vec_t     exp_clean;
  btn_vec_t     exp_held;
  int           rise_edge [N];

  button_debouncer #(
    .N_BTN(N), .SYNC_STAGES(SS), .STABLE_CYCLES(ST), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_clean(btn_clean), .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the reference model with the values
  // present at that edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    logic v;
    logic same;
    @(posedge clk);
    edge_no++;
    if (reset) begin
      for (int j = 0; j < HD; j++) hist[j] = '0;
      exp_clean = '0;
      exp_held  = '0;
    end else begin
      for (int b = 0; b < N; b++) begin
        v = hist[SS-1][b];
        same = 1'b1;
        for (int j = SS - 1; j < HD; j++) if (hist[j][b] != v) same = 1'b0;
        if (same && (v != exp_clean[b])) begin
          exp_clean[b] = v;
          if (v) rise_edge[b] = edge_no;
        end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        exp_held[b] = exp_clean[b] && ((edge_no - rise_edge[b]) >= HC);
`else
        exp_held[b] = 1'b0;
`endif
      end
      for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_raw;
    end
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 5'b11111;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (btn_clean !== 5'b00000 || btn_held !== 5'b00000) begin
        bad++;
        $display("FAIL reset_hold clean=%b held=%b want 00000/00000", btn_clean, btn_held);
      end
    end
    reset = 1'b0;
    tick();
    total++;
    if (btn_clean !== 5'b00000 || btn_held !== 5'b00000) begin
      bad++;
      $display("FAIL reset_release clean=%b held=%b want 00000/00000", btn_clean, btn_held);
    end
    btn_raw = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (btn_clean !== exp_clean || btn_held !== exp_held) begin
        bad++;
        $display("FAIL reset_settle clean=%b/%b held=%b/%b", btn_clean, exp_clean, btn_held, exp_held);
      end
    end
    $display("test_reset done edge=%0d", edge_no);
  endtask

  task automatic test_press();
    int lat;
    lat = 0;
    btn_raw = 5'b00001;
    do begin
      tick();
      lat++;
      total++;
      if (btn_clean !== exp_clean || btn_clean[4:1] !== 4'b0000) begin
        bad++;
        $display("FAIL press_track clean=%b want %b", btn_clean, exp_clean);
      end
    end while (!btn_clean[0] && lat < 20);
    total++;
    if (lat !== SS + ST) begin
      bad++;
      $display("FAIL press_latency got=%0d want=%0d", lat, SS + ST);
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL press_release clean=%b want %b", btn_clean, exp_clean);
      end
    end
    $display("test_press done latency=%0d", lat);
  endtask

  task automatic test_glitch();
    int lat;
    for (int i = 0; i < 9; i++) begin
      btn_raw = (i < 3) ? 5'b00010 : 5'b00000;
      tick();
      total++;
      if (btn_clean[1] !== 1'b0 || btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL glitch_reject clean=%b want %b", btn_clean, exp_clean);
      end
    end
    lat = 0;
    btn_raw = 5'b00010;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (btn_clean[1] && lat == 0) lat = i + 1;
      total++;
      if (btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL glitch_press clean=%b want %b", btn_clean, exp_clean);
      end
    end
    total++;
    if (lat !== SS + ST) begin
      bad++;
      $display("FAIL glitch_latency got=%0d want=%0d", lat, SS + ST);
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    $display("test_glitch done latency=%0d", lat);
  endtask

  task automatic test_bounce();
    logic [11:0] pat;
    int rise_at;
    int fall_at;
    pat = 12'b1111_1110_1101;
    rise_at = -1;
    for (int i = 0; i < 12; i++) begin
      btn_raw = {2'b00, pat[i], 2'b00};
      tick();
      if (btn_clean[2] && rise_at < 0) rise_at = i;
      total++;
      if (btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL bounce_rise_track clean=%b want %b", btn_clean, exp_clean);
      end
    end
    total++;
    if (rise_at !== 5 + SS + ST - 1) begin
      bad++;
      $display("FAIL bounce_rise_edge got=%0d want=%0d", rise_at, 5 + SS + ST - 1);
    end
    fall_at = -1;
    for (int i = 0; i < 12; i++) begin
      btn_raw = {2'b00, ~pat[i], 2'b00};
      tick();
      if (!btn_clean[2] && fall_at < 0) fall_at = i;
      total++;
      if (btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL bounce_fall_track clean=%b want %b", btn_clean, exp_clean);
      end
    end
    total++;
    if (fall_at !== 5 + SS + ST - 1) begin
      bad++;
      $display("FAIL bounce_fall_edge got=%0d want=%0d", fall_at, 5 + SS + ST - 1);
    end
    $display("test_bounce done rise=%0d fall=%0d", rise_at, fall_at);
  endtask

  task automatic test_simultaneous();
    int lat;
    lat = 0;
    btn_raw = 5'b10101;
    do begin
      tick();
      lat++;
      total++;
      if (btn_clean !== exp_clean || (btn_clean !== 5'b00000 && btn_clean !== 5'b10101)) begin
        bad++;
        $display("FAIL simul_track clean=%b want %b", btn_clean, exp_clean);
      end
    end while (btn_clean !== 5'b10101 && lat < 20);
    total++;
    if (lat !== SS + ST) begin
      bad++;
      $display("FAIL simul_latency got=%0d want=%0d", lat, SS + ST);
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    $display("test_simultaneous done latency=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    btn_raw = 5'b10101;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (btn_clean !== 5'b00000) begin
      bad++;
      $display("FAIL midreset_clear clean=%b want 00000", btn_clean);
    end
    lat = 0;
    do begin
      tick();
      lat++;
      total++;
      if (btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL midreset_track clean=%b want %b", btn_clean, exp_clean);
      end
    end while (btn_clean !== 5'b10101 && lat < 20);
    total++;
    if (lat !== SS + ST) begin
      bad++;
      $display("FAIL midreset_latency got=%0d want=%0d", lat, SS + ST);
    end
    btn_raw = '0;
    for (int i = 0; i < 8; i++) tick();
    $display("test_reset_mid done latency=%0d", lat);
  endtask

  task automatic test_hold();
    int n;
    n = 0;
    btn_raw = 5'b01000;
    do begin tick(); n++; end while (!btn_clean[3] && n < 20);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_held[3] && n == 0) n = i + 1;
      total++;
      if (btn_held !== exp_held || btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL hold_track held=%b/%b clean=%b/%b", btn_held, exp_held, btn_clean, exp_clean);
      end
    end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    total++;
    if (n !== HC) begin
      bad++;
      $display("FAIL hold_latency got=%0d want=%0d", n, HC);
    end
`else
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL hold_disabled held rose after %0d edges want never", n);
    end
`endif
    btn_raw = '0;
    n = 0;
    do begin
      tick();
      n++;
      total++;
      if (btn_held !== exp_held || btn_clean !== exp_clean) begin
        bad++;
        $display("FAIL hold_release held=%b/%b clean=%b/%b", btn_held, exp_held, btn_clean, exp_clean);
      end
    end while (btn_clean[3] && n < 20);
    total++;
    if (btn_held[3] !== 1'b0 || btn_clean[3] !== 1'b0) begin
      bad++;
      $display("FAIL hold_fall_same_edge held=%b clean=%b want 0/0", btn_held[3], btn_clean[3]);
    end
    $display("test_hold done release_edges=%0d", n);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) btn_raw[b] = ~btn_raw[b];
      reset = ($urandom_range(99) == 0);
      tick();
      total++;
      if (btn_clean !== exp_clean || btn_held !== exp_held) begin
        bad++;
        $display("FAIL random_%0d clean=%b/%b held=%b/%b", i, btn_clean, exp_clean, btn_held, exp_held);
      end
    end
    reset = 1'b0;
    $display("test_random done edge=%0d", edge_no);
  endtask

  initial begin
    for (int j = 0; j < HD; j++) hist[j] = '0;
    for (int b = 0; b < N; b++) rise_edge[b] = 0;
    exp_clean = '0;
    exp_held  = '0;
    reset     = 1'b1;
    btn_raw   = '0;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
